// File: rtl/disp_sched.sv
// Fixed-priority scheduler for the shared 6-digit LED display: alarm > overlay > default view.
// Owns the overlay hold timer, the blink timebase and the registered segment/dp outputs.
module disp_sched #(
    parameter int HOLD_TICKS  = 200,
    parameter int BLINK_TICKS = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tick,
    input  logic [41:0] i_src0_seg,
    input  logic [5:0]  i_src0_dp,
    input  logic [5:0]  i_blink_mask,
    input  logic [41:0] i_src1_seg,
    input  logic [5:0]  i_src1_dp,
    input  logic        i_src1_req,
    input  logic [41:0] i_src2_seg,
    input  logic [5:0]  i_src2_dp,
    input  logic        i_src2_req,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp,
    output logic [1:0]  o_grant,
    output logic        o_src1_busy
);

    typedef enum logic [1:0] {S_DEF = 2'd0, S_OVL = 2'd1, S_ALM = 2'd2} state_e;

    localparam logic [15:0] HOLD_LD   = 16'(HOLD_TICKS);
    localparam logic [7:0]  BLINK_MAX = 8'(BLINK_TICKS - 1);

    state_e      state_q, state_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_ph_q, blink_ph_d;
    logic [41:0] seg_q, seg_d;
    logic [5:0]  dp_q, dp_d;
    logic        busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DEF;
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= '0;
            dp_q        <= '0;
            o_grant     <= '0;
            o_src1_busy <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            o_grant     <= state_d;
            o_src1_busy <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_DEF: begin
                if (i_src2_req)      state_d = S_ALM;
                else if (i_src1_req) state_d = S_OVL;
            end
            S_OVL: begin
                if (i_src2_req) state_d = S_ALM;
                else if (i_tick && hold_cnt_q == 16'd1 && !i_src1_req) state_d = S_DEF;
            end
            S_ALM: begin
                // A request arriving on the release cycle still counts as a queued overlay.
                if (!i_src2_req)
                    state_d = (hold_cnt_q != '0 || i_src1_req) ? S_OVL : S_DEF;
            end
            default: state_d = S_DEF;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (i_src1_req)
            hold_cnt_d = HOLD_LD;
        else if (state_q == S_OVL && !i_src2_req && i_tick && hold_cnt_q != '0)
            hold_cnt_d = hold_cnt_q - 16'd1;
        busy_d = (hold_cnt_d != '0);
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (state_q != S_ALM && state_d == S_ALM) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (i_tick) begin
            if (blink_cnt_q >= BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    // Mux follows the next state and next blink phase so data lands with o_grant.
    always_comb begin
        seg_d = i_src0_seg;
        dp_d  = i_src0_dp;
        unique case (state_d)
            S_OVL: begin
                seg_d = i_src1_seg;
                dp_d  = i_src1_dp;
            end
            S_ALM: begin
                seg_d = blink_ph_d ? '0 : i_src2_seg;
                dp_d  = blink_ph_d ? '0 : i_src2_dp;
            end
            default: begin
                for (int k = 0; k < 6; k++) begin
                    if (i_blink_mask[k] && blink_ph_d) begin
                        seg_d[7*k +: 7] = 7'b000_0000;
                        dp_d[k]         = 1'b0;
                    end
                end
            end
        endcase
    end

    assign o_six_digit_seg = seg_q;
    assign o_six_dp        = dp_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with HOLD_TICKS=4, BLINK_TICKS=2 and a tick every 10 clk.
module tb_disp_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_tick = 1'b0;
    logic [41:0] i_src0_seg, i_src1_seg, i_src2_seg;
    logic [5:0]  i_src0_dp, i_src1_dp, i_src2_dp, i_blink_mask;
    logic        i_src1_req = 1'b0, i_src2_req = 1'b0;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;
    logic [1:0]  o_grant;
    logic        o_src1_busy;

    int total = 0;
    int bad   = 0;

    localparam logic [41:0] S0 = 42'h0123456789A;
    localparam logic [41:0] S1 = 42'h3FF00FF00FF;
    localparam logic [41:0] S2 = 42'h15555555555;
    localparam logic [41:0] S0_MASKED = 42'h01234564000;

    disp_sched #(.HOLD_TICKS(4), .BLINK_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick),
        .i_src0_seg(i_src0_seg), .i_src0_dp(i_src0_dp), .i_blink_mask(i_blink_mask),
        .i_src1_seg(i_src1_seg), .i_src1_dp(i_src1_dp), .i_src1_req(i_src1_req),
        .i_src2_seg(i_src2_seg), .i_src2_dp(i_src2_dp), .i_src2_req(i_src2_req),
        .o_six_digit_seg(o_six_digit_seg), .o_six_dp(o_six_dp),
        .o_grant(o_grant), .o_src1_busy(o_src1_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock with the given tick value; returns 1 ns after the edge.
    task automatic cyc(input logic t);
        i_tick = t;
        @(posedge clk);
        #1;
        i_tick = 1'b0;
    endtask

    // One tick period: nine idle clocks then the tick clock, optionally with an overlay request.
    task automatic tick(input logic req);
        for (int i = 0; i < 9; i++) cyc(1'b0);
        i_src1_req = req;
        cyc(1'b1);
        i_src1_req = 1'b0;
    endtask

    task automatic pulse_src1();
        i_src1_req = 1'b1;
        cyc(1'b0);
        i_src1_req = 1'b0;
    endtask

    initial begin
        i_src0_seg = S0;  i_src0_dp = 6'h2D;
        i_src1_seg = S1;  i_src1_dp = 6'h15;
        i_src2_seg = S2;  i_src2_dp = 6'h3F;
        i_blink_mask = 6'b0;

        // Reset values, then first output one clock after release
        repeat (2) cyc(1'b0);
        chk("rst_seg", 48'(o_six_digit_seg), 48'h0);
        chk("rst_grant", 48'(o_grant), 48'd0);
        chk("rst_busy", 48'(o_src1_busy), 48'd0);
        rst_n = 1'b1;
        cyc(1'b0);
        chk("def_seg", 48'(o_six_digit_seg), 48'(S0));
        chk("def_dp", 48'(o_six_dp), 48'h2D);
        chk("def_grant", 48'(o_grant), 48'd0);
        chk("def_busy", 48'(o_src1_busy), 48'd0);

        // Live source data is re-sampled every clock
        i_src0_seg = 42'h2BCDEF01234;
        cyc(1'b0);
        chk("live_seg", 48'(o_six_digit_seg), 48'h2BCDEF01234);
        i_src0_seg = S0;
        cyc(1'b0);

        // Overlay for 4 ticks
        pulse_src1();
        chk("ovl_grant", 48'(o_grant), 48'd1);
        chk("ovl_busy", 48'(o_src1_busy), 48'd1);
        chk("ovl_seg", 48'(o_six_digit_seg), 48'(S1));
        chk("ovl_dp", 48'(o_six_dp), 48'h15);
        for (int k = 1; k <= 3; k++) tick(1'b0);
        chk("ovl_t3_grant", 48'(o_grant), 48'd1);
        tick(1'b0);
        chk("ovl_end_grant", 48'(o_grant), 48'd0);
        chk("ovl_end_busy", 48'(o_src1_busy), 48'd0);
        chk("ovl_end_seg", 48'(o_six_digit_seg), 48'(S0));

        // Reload on the 3rd tick: 7 ticks in total
        pulse_src1();
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        for (int k = 4; k <= 6; k++) tick(1'b0);
        chk("rld_t6_grant", 48'(o_grant), 48'd1);
        chk("rld_t6_busy", 48'(o_src1_busy), 48'd1);
        tick(1'b0);
        chk("rld_t7_grant", 48'(o_grant), 48'd0);
        chk("rld_t7_busy", 48'(o_src1_busy), 48'd0);

        // Alarm interrupts overlay with hold_cnt 2
        pulse_src1();
        tick(1'b0);
        tick(1'b0);
        i_src2_req = 1'b1;
        cyc(1'b0);
        chk("alm_grant", 48'(o_grant), 48'd2);
        chk("alm_seg0", 48'(o_six_digit_seg), 48'(S2));
        chk("alm_busy", 48'(o_src1_busy), 48'd1);
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0);
            chk($sformatf("alm_seg_t%0d", k), 48'(o_six_digit_seg),
                ((k / 2) % 2 == 1) ? 48'h0 : 48'(S2));
            chk($sformatf("alm_dp_t%0d", k), 48'(o_six_dp),
                ((k / 2) % 2 == 1) ? 48'h0 : 48'h3F);
        end
        chk("alm_end_busy", 48'(o_src1_busy), 48'd1);
        i_src2_req = 1'b0;
        cyc(1'b0);
        chk("alm_rel_grant", 48'(o_grant), 48'd1);
        chk("alm_rel_seg", 48'(o_six_digit_seg), 48'(S1));
        tick(1'b0);
        chk("alm_rel_t1_grant", 48'(o_grant), 48'd1);
        tick(1'b0);
        chk("alm_rel_t2_grant", 48'(o_grant), 48'd0);
        chk("alm_rel_t2_busy", 48'(o_src1_busy), 48'd0);

        // Setup-digit blink; phase is 0 with counter 0 at this point
        i_blink_mask = 6'b000011;
        cyc(1'b0);
        chk("blk_t0_seg", 48'(o_six_digit_seg), 48'(S0));
        for (int k = 1; k <= 8; k++) begin
            tick(1'b0);
            chk($sformatf("blk_seg_t%0d", k), 48'(o_six_digit_seg),
                ((k / 2) % 2 == 1) ? 48'(S0_MASKED) : 48'(S0));
            chk($sformatf("blk_dp_t%0d", k), 48'(o_six_dp),
                ((k / 2) % 2 == 1) ? 48'h2C : 48'h2D);
        end
        i_blink_mask = 6'b0;

        // Asynchronous reset during alarm drops the queued overlay
        i_src2_req = 1'b1;
        pulse_src1();
        chk("arst_pre_grant", 48'(o_grant), 48'd2);
        chk("arst_pre_busy", 48'(o_src1_busy), 48'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", 48'(o_six_digit_seg), 48'h0);
        chk("arst_grant", 48'(o_grant), 48'd0);
        chk("arst_busy", 48'(o_src1_busy), 48'd0);
        i_src2_req = 1'b0;
        #1 rst_n = 1'b1;
        cyc(1'b0);
        chk("arst_rel_grant", 48'(o_grant), 48'd0);
        chk("arst_rel_busy", 48'(o_src1_busy), 48'd0);
        chk("arst_rel_seg", 48'(o_six_digit_seg), 48'(S0));
        tick(1'b0);
        chk("arst_t1_grant", 48'(o_grant), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
